// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: de/hsync/vsync, pixel coordinates and line/frame markers.
// Optional macro VIDEO_TIMING_PREFETCH_EN adds pix_req/req_x/req_y, leading de/x/y by LEAD cycles.
module video_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12,
    parameter int LEAD     = 1
) (
    input  logic          clk_pixel,
    input  logic          resetn,
    input  logic          restart,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
`ifdef VIDEO_TIMING_PREFETCH_EN
    output logic          frame_start,
    output logic          pix_req,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y
`else
    output logic          frame_start
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Elaboration-time guards on the mode parameters.
    if ((2 ** CW) <= H_TOTAL || (2 ** CW) <= V_TOTAL) begin : g_cw_check
        $error("video_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
    if (LEAD < 1 || LEAD >= H_TOTAL) begin : g_lead_check
        $error("video_timing_gen: LEAD must satisfy 1 <= LEAD < H_TOTAL");
    end

    // Raster step shared by the display and prefetch counter pairs; returns {v, h}.
    function automatic logic [2*CW-1:0] advance(input logic [CW-1:0] h, input logic [CW-1:0] v);
        logic [CW-1:0] h_n;
        logic [CW-1:0] v_n;
        h_n = (h == H_LAST) ? '0 : h + CW'(1);
        v_n = v;
        if (h == H_LAST) begin
            v_n = (v == V_LAST) ? '0 : v + CW'(1);
        end
        return {v_n, h_n};
    endfunction

    function automatic logic de_of(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return (h < H_ACT) && (v < V_ACT);
    endfunction

    function automatic logic hs_of(input logic [CW-1:0] h);
        return ((h >= HS_START) && (h < HS_END)) ^ ~HS_POL;
    endfunction

    function automatic logic vs_of(input logic [CW-1:0] v);
        return ((v >= VS_START) && (v < VS_END)) ^ ~VS_POL;
    endfunction

    logic [CW-1:0] hc, vc;
    logic [CW-1:0] hc_next, vc_next;

    // NOTE: every variable assigned in always_comb gets a value on every path first, so no latch is inferred.
    always_comb begin
        {vc_next, hc_next} = advance(hc, vc);
        if (restart) begin
            hc_next = '0;
            vc_next = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            hc          <= '0;
            vc          <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            de          <= de_of(hc, vc);
            hsync       <= hs_of(hc);
            vsync       <= vs_of(vc);
            x           <= hc;
            y           <= vc;
            line_start  <= (hc == '0);
            frame_start <= (hc == '0) && (vc == '0);
        end
    end

`ifdef VIDEO_TIMING_PREFETCH_EN
    localparam logic [CW-1:0] LEAD_W = CW'(LEAD);

    logic [CW-1:0] rhc, rvc;
    logic [CW-1:0] rhc_next, rvc_next;

    // Request counters run LEAD positions ahead; LEAD < H_TOTAL keeps the start on line 0.
    always_comb begin
        {rvc_next, rhc_next} = advance(rhc, rvc);
        if (restart) begin
            rhc_next = LEAD_W;
            rvc_next = '0;
        end
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            rhc     <= LEAD_W;
            rvc     <= '0;
            pix_req <= 1'b0;
            req_x   <= '0;
            req_y   <= '0;
        end else begin
            rhc     <= rhc_next;
            rvc     <= rvc_next;
            pix_req <= de_of(rhc, rvc);
            req_x   <= rhc;
            req_y   <= rvc;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: default 1344x806 mode plus a small 14x8 mode,
// checked every cycle against a linear-pixel-index model of the raster.
module tb_video_timing_gen;

    localparam int CWD = 12;
    localparam int CWS = 8;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp, lead;
        bit hpol, vpol;
    } tim_t;

    typedef struct {
        logic de, hs, vs, ls, fs, rq;
        int   x, y, rx, ry;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic restart_d = 1'b0;
    logic restart_s = 1'b0;

    always #5 clk = ~clk;

    logic           d_de, d_hsync, d_vsync, d_line_start, d_frame_start;
    logic [CWD-1:0] d_x, d_y;
    logic           s_de, s_hsync, s_vsync, s_line_start, s_frame_start;
    logic [CWS-1:0] s_x, s_y;
`ifdef VIDEO_TIMING_PREFETCH_EN
    logic           d_pix_req, s_pix_req;
    logic [CWD-1:0] d_req_x, d_req_y;
    logic [CWS-1:0] s_req_x, s_req_y;
`endif

    video_timing_gen u_dut_d (
        .clk_pixel  (clk),
        .resetn     (resetn),
        .restart    (restart_d),
        .de         (d_de),
        .hsync      (d_hsync),
        .vsync      (d_vsync),
        .x          (d_x),
        .y          (d_y),
        .line_start (d_line_start),
        .frame_start(d_frame_start)
`ifdef VIDEO_TIMING_PREFETCH_EN
       ,.pix_req    (d_pix_req),
        .req_x      (d_req_x),
        .req_y      (d_req_y)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CWS), .LEAD(3)
    ) u_dut_s (
        .clk_pixel  (clk),
        .resetn     (resetn),
        .restart    (restart_s),
        .de         (s_de),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .x          (s_x),
        .y          (s_y),
        .line_start (s_line_start),
        .frame_start(s_frame_start)
`ifdef VIDEO_TIMING_PREFETCH_EN
       ,.pix_req    (s_pix_req),
        .req_x      (s_req_x),
        .req_y      (s_req_y)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the output position is a linear pixel index p within the frame.
    tim_t td, ts;
    int   p_d, p_s;
    bit   load_d, load_s, valid_d, valid_s;

    function automatic int total_of(input tim_t t);
        return (t.ha + t.hfp + t.hs + t.hbp) * (t.va + t.vfp + t.vs + t.vbp);
    endfunction

    function automatic exp_t expect_of(input tim_t t, input int p, input bit valid);
        exp_t e;
        int ht, px, py, q;
        ht   = t.ha + t.hfp + t.hs + t.hbp;
        e.de = 1'b0; e.hs = ~t.hpol; e.vs = ~t.vpol; e.ls = 1'b0; e.fs = 1'b0;
        e.x  = 0;    e.y  = 0;       e.rq = 1'b0;    e.rx = 0;    e.ry = 0;
        if (valid) begin
            px   = p % ht;
            py   = p / ht;
            e.x  = px;
            e.y  = py;
            e.de = (px < t.ha) && (py < t.va);
            e.hs = (px >= t.ha + t.hfp && px < t.ha + t.hfp + t.hs) ? t.hpol : ~t.hpol;
            e.vs = (py >= t.va + t.vfp && py < t.va + t.vfp + t.vs) ? t.vpol : ~t.vpol;
            e.ls = (px == 0);
            e.fs = (p == 0);
            q    = (p + t.lead) % total_of(t);
            e.rx = q % ht;
            e.ry = q / ht;
            e.rq = (e.rx < t.ha) && (e.ry < t.va);
        end
        return e;
    endfunction

    task automatic model_reset();
        p_d = 0; p_s = 0;
        load_d = 1'b1; load_s = 1'b1;
        valid_d = 1'b0; valid_s = 1'b0;
    endtask

    task automatic cmp_d(input string ph);
        exp_t e;
        e = expect_of(td, p_d, valid_d);
        check({ph, "/d.de"},          32'(d_de),          32'(e.de));
        check({ph, "/d.hsync"},       32'(d_hsync),       32'(e.hs));
        check({ph, "/d.vsync"},       32'(d_vsync),       32'(e.vs));
        check({ph, "/d.x"},           32'(d_x),           32'(e.x));
        check({ph, "/d.y"},           32'(d_y),           32'(e.y));
        check({ph, "/d.line_start"},  32'(d_line_start),  32'(e.ls));
        check({ph, "/d.frame_start"}, 32'(d_frame_start), 32'(e.fs));
`ifdef VIDEO_TIMING_PREFETCH_EN
        check({ph, "/d.pix_req"},     32'(d_pix_req),     32'(e.rq));
        check({ph, "/d.req_x"},       32'(d_req_x),       32'(e.rx));
        check({ph, "/d.req_y"},       32'(d_req_y),       32'(e.ry));
`endif
    endtask

    task automatic cmp_s(input string ph);
        exp_t e;
        e = expect_of(ts, p_s, valid_s);
        check({ph, "/s.de"},          32'(s_de),          32'(e.de));
        check({ph, "/s.hsync"},       32'(s_hsync),       32'(e.hs));
        check({ph, "/s.vsync"},       32'(s_vsync),       32'(e.vs));
        check({ph, "/s.x"},           32'(s_x),           32'(e.x));
        check({ph, "/s.y"},           32'(s_y),           32'(e.y));
        check({ph, "/s.line_start"},  32'(s_line_start),  32'(e.ls));
        check({ph, "/s.frame_start"}, 32'(s_frame_start), 32'(e.fs));
`ifdef VIDEO_TIMING_PREFETCH_EN
        check({ph, "/s.pix_req"},     32'(s_pix_req),     32'(e.rq));
        check({ph, "/s.req_x"},       32'(s_req_x),       32'(e.rx));
        check({ph, "/s.req_y"},       32'(s_req_y),       32'(e.ry));
`endif
    endtask

    // Drive restarts at the falling edge, advance the model on the rising edge, compare at the next fall.
    task automatic cycle(input string ph, input logic rd, input logic rs);
        restart_d = rd;
        restart_s = rs;
        @(posedge clk);
        if (resetn) begin
            p_d = load_d ? 0 : (p_d + 1) % total_of(td);
            p_s = load_s ? 0 : (p_s + 1) % total_of(ts);
            load_d = rd; load_s = rs;
            valid_d = 1'b1; valid_s = 1'b1;
        end
        @(negedge clk);
        cmp_d(ph);
        cmp_s(ph);
    endtask

    // Interval measurements taken directly from the DUT outputs.
    int   cyc = 0;
    int   last_ls_d = -1, de_cnt_d = 0, hs_cnt_d = 0;
    bit   line_ok_d = 1'b0;
    logic hs_prev_d = 1'b1;
    int   last_fs_s = -1, de_cnt_s = 0;
    bit   frame_ok_s = 1'b0;
    logic vs_prev_s = 1'b0;

    task automatic measure_d();
        if (d_line_start) begin
            if (last_ls_d >= 0) check("d.line_period", 32'(cyc - last_ls_d), 32'd1344);
            if (line_ok_d) begin
                check("d.de_per_line", 32'(de_cnt_d), 32'd1024);
                check("d.hs_per_line", 32'(hs_cnt_d), 32'd136);
            end
            last_ls_d = cyc; line_ok_d = 1'b1; de_cnt_d = 0; hs_cnt_d = 0;
        end
        if (d_de) de_cnt_d++;
        if (!d_hsync) begin
            hs_cnt_d++;
            if (hs_prev_d) check("d.hs_start_x", 32'(d_x), 32'd1048);
        end
        hs_prev_d = d_hsync;
    endtask

    task automatic measure_s();
        if (s_frame_start) begin
            if (last_fs_s >= 0) check("s.frame_period", 32'(cyc - last_fs_s), 32'd112);
            if (frame_ok_s) check("s.de_per_frame", 32'(de_cnt_s), 32'd32);
            last_fs_s = cyc; frame_ok_s = 1'b1; de_cnt_s = 0;
        end
        if (s_de) de_cnt_s++;
        if (s_vsync && !vs_prev_s) begin
            check("s.vs_rise_y", 32'(s_y), 32'd5);
            check("s.vs_rise_x", 32'(s_x), 32'd0);
        end
        if (!s_vsync && vs_prev_s) begin
            check("s.vs_fall_y", 32'(s_y), 32'd7);
            check("s.vs_fall_x", 32'(s_x), 32'd0);
        end
        vs_prev_s = s_vsync;
    endtask

    initial begin
        bit rd, rs, restarted;
        int rs_age, hold;
        td = '{ha: 1024, hfp: 24, hs: 136, hbp: 160, va: 768, vfp: 3, vs: 6, vbp: 29,
               lead: 1, hpol: 1'b0, vpol: 1'b0};
        ts = '{ha: 8, hfp: 2, hs: 3, hbp: 1, va: 4, vfp: 1, vs: 2, vbp: 1,
               lead: 3, hpol: 1'b1, vpol: 1'b1};
        model_reset();

        // Held in reset: outputs at reset values across several edges.
        repeat (3) begin
            @(negedge clk);
            cmp_d("reset");
            cmp_s("reset");
        end
        check("reset/d.hsync_level", 32'(d_hsync), 32'd1);
        check("reset/d.vsync_level", 32'(d_vsync), 32'd1);
        resetn = 1'b1;

        // Default mode: two clean lines, a restart at x=500 y=2, three more lines; small mode free-runs.
        restarted = 1'b0;
        rs_age = -1;
        for (int i = 0; i < 7400; i++) begin
            rd = !restarted && valid_d && (p_d == 2 * 1344 + 500);
            if (rd) begin
                restarted = 1'b1; rs_age = 0; last_ls_d = -1; line_ok_d = 1'b0;
            end
            cycle("free", rd, 1'b0);
            if (i == 0) begin
                check("first/d.de", 32'(d_de), 32'd1);
                check("first/d.frame_start", 32'(d_frame_start), 32'd1);
                check("first/d.x", 32'(d_x), 32'd0);
                check("first/d.y", 32'(d_y), 32'd0);
            end
            if (rs_age >= 0) rs_age++;
            if (rs_age == 2) begin
                check("restart/d.x", 32'(d_x), 32'd0);
                check("restart/d.y", 32'(d_y), 32'd0);
                check("restart/d.frame_start", 32'(d_frame_start), 32'd1);
            end
            if (rs_age == 3) check("restart/d.x_next", 32'(d_x), 32'd1);
            measure_d();
            measure_s();
            cyc++;
        end

        // Random restarts, including held bursts on the small mode.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold > 0) begin
                rs = 1'b1; hold--;
            end else if ($urandom_range(0, 59) == 0) begin
                rs = 1'b1; hold = $urandom_range(1, 4);
            end else begin
                rs = ($urandom_range(0, 29) == 0);
            end
            rd = ($urandom_range(0, 499) == 0);
            cycle("rand", rd, rs);
        end

        // Asynchronous reset between edges, observed before any further edge.
        restart_d = 1'b0;
        restart_s = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        cmp_d("async");
        cmp_s("async");
        @(negedge clk);
        cmp_d("async_hold");
        cmp_s("async_hold");
        resetn = 1'b1;

        for (int i = 0; i < 400; i++) begin
            cycle("post", ($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
